fir_out_buffer: RTL and testbench
=================================

FIR_OUT_BUFFER -- requirements
Module: fir_out_buffer

Interface
REQ-001 SHALL have parameter WIDTH, default 8, sample width, matching the filter DOUT.
REQ-002 SHALL have parameter DEPTH, default 8, FIFO entries; power of two, minimum 2.
REQ-003 SHALL have port CLK  input  1  single clock; all state on the rising edge.
REQ-004 SHALL have port RST_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port VIN  input  1  sample valid from the filter VOUT.
REQ-006 SHALL have port DIN  input  WIDTH  sample from the filter DOUT.
REQ-007 SHALL have port CLR  input  1  synchronous flush.
REQ-008 SHALL have port RDY  input  1  downstream consumer ready.
REQ-009 SHALL have port VOUT  output  1  head sample valid.
REQ-010 SHALL have port DOUT  output  WIDTH  head sample.
REQ-011 SHALL have port FULL  output  1  count equals DEPTH.
REQ-012 SHALL have port EMPTY  output  1  count equals 0.
REQ-013 SHALL have port OVF  output  1  sticky overflow flag.
REQ-014 SHALL have port COUNT  output  log2(DEPTH)+1  occupancy.

Function
REQ-015 SHALL accept a write when VIN=1 and FULL=0 at the clock edge, storing DIN at the write pointer.
REQ-016 SHALL drop the sample and set OVF when VIN=1 and FULL=1, even if a read occurs in the same cycle.
REQ-017 SHALL perform a read (pop) when VOUT=1 and RDY=1 at the clock edge.
REQ-018 SHALL be first-word fall-through: VOUT = not EMPTY, and DOUT = mem[rd_ptr] with no read latency.
REQ-019 SHALL raise VOUT in the cycle after the first write into an empty buffer (write-to-VOUT latency 1).
REQ-020 SHALL, on a simultaneous accepted write and read, leave COUNT unchanged and advance both pointers.
REQ-021 SHALL wrap read and write pointers modulo DEPTH.
REQ-022 SHALL keep COUNT within 0..DEPTH; FULL and EMPTY SHALL be registered-state decodes of COUNT.
REQ-023 SHALL hold DOUT at the last head value when EMPTY; consumers SHALL qualify DOUT with VOUT.
REQ-024 SHALL keep OVF high until reset or CLR.
REQ-025 SHALL, on CLR=1, zero pointers, COUNT and OVF at the next edge and ignore VIN and RDY in that cycle.

Reset
REQ-026 SHALL, while RST_n=0, asynchronously force pointers=0, COUNT=0, EMPTY=1, FULL=0, VOUT=0, OVF=0, DOUT=0.
REQ-027 SHALL abandon any stored samples on reset mid-operation; memory contents need not be cleared.
REQ-028 SHALL resume normal operation on the first rising CLK edge after RST_n deasserts.

Configuration
REQ-029 SHALL, with FIR_OUT_BUFFER_STATS_EN defined, add outputs SAMPLES (16 bits, accepted writes) and DROPS (16 bits, dropped writes).
REQ-030 SHALL saturate SAMPLES and DROPS at 0xFFFF; reset and CLR SHALL zero both counters.
REQ-031 SHALL, without FIR_OUT_BUFFER_STATS_EN, omit SAMPLES, DROPS and their logic, with all other behaviour identical.

Verification
REQ-032 SHALL verify single write, DEPTH=8: VIN=1, DIN=0x5A for 1 cycle with RDY=0 -> next cycle VOUT=1, DOUT=0x5A, COUNT=1; RDY=1 -> EMPTY=1 a cycle later.
REQ-033 SHALL verify fill and overflow: 10 writes 0x01..0x0A with RDY=0 -> FULL=1 after the 8th; OVF=1; 0x09 and 0x0A are lost; DROPS=2 when stats are enabled; draining yields 0x01..0x08 in order.
REQ-034 SHALL verify full with simultaneous read and write: buffer full, VIN=1 and RDY=1 -> head popped, new sample dropped, OVF=1, COUNT=7.
REQ-035 SHALL verify streaming: VIN=1 and RDY=1 every cycle for 20 samples -> COUNT never exceeds 1, output order equals input order, OVF=0, pointers wrap twice.
REQ-036 SHALL verify mid-operation reset: COUNT=5 and OVF=1, RST_n pulsed low between edges -> immediately VOUT=0, EMPTY=1, OVF=0, COUNT=0.
REQ-037 SHALL verify CLR: COUNT=3, CLR=1 with VIN=1 -> next cycle COUNT=0 and the VIN sample is not stored.

Source files
------------

// File: rtl/fir_out_buffer.sv
// First-word fall-through output FIFO for the FIR filter sample stream.
// Optional write/drop counters are enabled by FIR_OUT_BUFFER_STATS_EN.
module fir_out_buffer #(
    parameter  int WIDTH = 8,
    parameter  int DEPTH = 8,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = AW + 1
) (
    input  logic             CLK,
    input  logic             RST_n,
    input  logic             VIN,
    input  logic [WIDTH-1:0] DIN,
    input  logic             CLR,
    input  logic             RDY,
    output logic             VOUT,
    output logic [WIDTH-1:0] DOUT,
    output logic             FULL,
    output logic             EMPTY,
    output logic             OVF,
    output logic [CW-1:0]    COUNT
`ifdef FIR_OUT_BUFFER_STATS_EN
    ,
    output logic [15:0]      SAMPLES,
    output logic [15:0]      DROPS
`endif
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CW-1:0]    count_q;
    logic [CW-1:0]    count_d;
    logic             full_q;
    logic             empty_q;
    logic             ovf_q;
    logic             wr_en;
    logic             rd_en;
    logic             drop;
    logic [WIDTH-1:0] last_q;

    // A full buffer drops the incoming sample even when a pop frees a slot.
    always_comb begin
        wr_en = VIN & ~full_q & ~CLR;
        drop  = VIN & full_q & ~CLR;
        rd_en = ~empty_q & RDY & ~CLR;
    end

    always_comb begin
        count_d = count_q;
        unique case ({wr_en, rd_en})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
            full_q  <= 1'b0;
            empty_q <= 1'b1;
            ovf_q   <= 1'b0;
        end else if (CLR) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
            full_q  <= 1'b0;
            empty_q <= 1'b1;
            ovf_q   <= 1'b0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + AW'(1);
            if (rd_en) rd_ptr <= rd_ptr + AW'(1);
            count_q <= count_d;
            full_q  <= (count_d == CW'(DEPTH));
            empty_q <= (count_d == '0);
            if (drop) ovf_q <= 1'b1;
        end
    end

    // Storage is not reset; stale entries are unreachable once pointers clear.
    always_ff @(posedge CLK) begin
        if (wr_en) mem[wr_ptr] <= DIN;
    end

    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            last_q <= '0;
        end else if (rd_en) begin
            last_q <= mem[rd_ptr];
        end
    end

    always_comb begin
        VOUT  = ~empty_q;
        DOUT  = empty_q ? last_q : mem[rd_ptr];
        FULL  = full_q;
        EMPTY = empty_q;
        OVF   = ovf_q;
        COUNT = count_q;
    end

`ifdef FIR_OUT_BUFFER_STATS_EN
    logic [15:0] samples_q;
    logic [15:0] drops_q;

    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            samples_q <= '0;
            drops_q   <= '0;
        end else if (CLR) begin
            samples_q <= '0;
            drops_q   <= '0;
        end else begin
            if (wr_en && samples_q != 16'hFFFF) samples_q <= samples_q + 16'd1;
            if (drop && drops_q != 16'hFFFF) drops_q <= drops_q + 16'd1;
        end
    end

    assign SAMPLES = samples_q;
    assign DROPS   = drops_q;
`endif

endmodule

// File: tb/tb_fir_out_buffer.sv
// Scoreboard bench for fir_out_buffer (DEPTH=8, WIDTH=8).
// Stats counters are checked when FIR_OUT_BUFFER_STATS_EN is defined.
module tb_fir_out_buffer;

    localparam int WIDTH = 8;
    localparam int DEPTH = 8;
    localparam int CW    = 4;

    logic             CLK = 1'b0;
    logic             RST_n = 1'b1;
    logic             VIN = 1'b0;
    logic [WIDTH-1:0] DIN = '0;
    logic             CLR = 1'b0;
    logic             RDY = 1'b0;
    logic             VOUT;
    logic [WIDTH-1:0] DOUT;
    logic             FULL;
    logic             EMPTY;
    logic             OVF;
    logic [CW-1:0]    COUNT;
`ifdef FIR_OUT_BUFFER_STATS_EN
    logic [15:0]      SAMPLES;
    logic [15:0]      DROPS;
`endif

    fir_out_buffer #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .CLK(CLK),
        .RST_n(RST_n),
        .VIN(VIN),
        .DIN(DIN),
        .CLR(CLR),
        .RDY(RDY),
        .VOUT(VOUT),
        .DOUT(DOUT),
        .FULL(FULL),
        .EMPTY(EMPTY),
        .OVF(OVF),
        .COUNT(COUNT)
`ifdef FIR_OUT_BUFFER_STATS_EN
        ,
        .SAMPLES(SAMPLES),
        .DROPS(DROPS)
`endif
    );

    always #5 CLK = ~CLK;

    int         n_chk = 0;
    int         n_err = 0;
    logic [7:0] sb [$];
    bit         ovf_m = 1'b0;
    int         samples_m = 0;
    int         drops_m = 0;
    int         max_cnt = 0;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        sb.delete();
        ovf_m     = 1'b0;
        samples_m = 0;
        drops_m   = 0;
    endtask

    task automatic cycle(input bit vin, input logic [7:0] din,
                         input bit rdy, input bit clr);
        bit full_m;
        @(negedge CLK);
        VIN = vin;
        DIN = din;
        RDY = rdy;
        CLR = clr;
        #1;
        check("vout", {31'd0, VOUT}, {31'd0, sb.size() != 0});
        if (clr) begin
            model_reset();
        end else begin
            full_m = (sb.size() == DEPTH);
            if (rdy && sb.size() != 0) begin
                check("dout", {24'd0, DOUT}, {24'd0, sb[0]});
                void'(sb.pop_front());
            end
            if (vin) begin
                if (!full_m) begin
                    sb.push_back(din);
                    samples_m++;
                end else begin
                    ovf_m = 1'b1;
                    drops_m++;
                end
            end
        end
        @(posedge CLK);
        #1;
        check("count", {28'd0, COUNT}, sb.size());
        check("ovf", {31'd0, OVF}, {31'd0, ovf_m});
        check("full", {31'd0, FULL}, {31'd0, sb.size() == DEPTH});
        check("empty", {31'd0, EMPTY}, {31'd0, sb.size() == 0});
`ifdef FIR_OUT_BUFFER_STATS_EN
        check("samples", {16'd0, SAMPLES}, samples_m);
        check("drops", {16'd0, DROPS}, drops_m);
`endif
        if (int'(COUNT) > max_cnt) max_cnt = int'(COUNT);
    endtask

    initial begin
        #2 RST_n = 1'b0;
        #1;
        check("rst_vout", {31'd0, VOUT}, 0);
        check("rst_empty", {31'd0, EMPTY}, 1);
        check("rst_full", {31'd0, FULL}, 0);
        check("rst_ovf", {31'd0, OVF}, 0);
        check("rst_count", {28'd0, COUNT}, 0);
        check("rst_dout", {24'd0, DOUT}, 0);
        @(negedge CLK);
        @(negedge CLK);
        RST_n = 1'b1;

        // single write, then pop
        cycle(1'b1, 8'h5A, 1'b0, 1'b0);
        check("sw_vout", {31'd0, VOUT}, 1);
        check("sw_dout", {24'd0, DOUT}, 32'h5A);
        check("sw_count", {28'd0, COUNT}, 1);
        cycle(1'b0, 8'h00, 1'b1, 1'b0);
        check("sw_empty", {31'd0, EMPTY}, 1);

        // fill past capacity, then drain in order
        for (int i = 1; i <= 10; i++) begin
            cycle(1'b1, 8'(i), 1'b0, 1'b0);
            if (i == 8) check("fill_full8", {31'd0, FULL}, 1);
        end
        check("fill_ovf", {31'd0, OVF}, 1);
        for (int i = 0; i < 8; i++) cycle(1'b0, 8'h00, 1'b1, 1'b0);
        check("drain_empty", {31'd0, EMPTY}, 1);
        check("drain_hold", {24'd0, DOUT}, 32'h08);
        cycle(1'b0, 8'h00, 1'b0, 1'b1);

        // full with simultaneous read and write
        for (int i = 0; i < 8; i++) cycle(1'b1, 8'(8'h20 + i), 1'b0, 1'b0);
        cycle(1'b1, 8'hEE, 1'b1, 1'b0);
        check("frw_count", {28'd0, COUNT}, 7);
        check("frw_ovf", {31'd0, OVF}, 1);

        // mid-operation reset with COUNT=5, OVF=1
        cycle(1'b0, 8'h00, 1'b1, 1'b0);
        cycle(1'b0, 8'h00, 1'b1, 1'b0);
        check("pre_rst_count", {28'd0, COUNT}, 5);
        @(negedge CLK);
        RDY = 1'b0;
        #2 RST_n = 1'b0;
        #1;
        model_reset();
        check("mrst_vout", {31'd0, VOUT}, 0);
        check("mrst_empty", {31'd0, EMPTY}, 1);
        check("mrst_ovf", {31'd0, OVF}, 0);
        check("mrst_count", {28'd0, COUNT}, 0);
        @(negedge CLK);
        RST_n = 1'b1;

        // CLR with VIN high discards the sample
        for (int i = 0; i < 3; i++) cycle(1'b1, 8'(8'h40 + i), 1'b0, 1'b0);
        check("clr_pre", {28'd0, COUNT}, 3);
        cycle(1'b1, 8'h77, 1'b0, 1'b1);
        check("clr_count", {28'd0, COUNT}, 0);
        cycle(1'b1, 8'h11, 1'b0, 1'b0);
        cycle(1'b0, 8'h00, 1'b1, 1'b0);

        // streaming: write and read every cycle
        max_cnt = 0;
        for (int i = 0; i < 20; i++) cycle(1'b1, 8'(8'h80 + i), 1'b1, 1'b0);
        cycle(1'b0, 8'h00, 1'b1, 1'b0);
        check("stream_max", max_cnt, 1);
        check("stream_ovf", {31'd0, OVF}, 0);
        check("stream_sb", sb.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_err);
        $finish;
    end

endmodule
